crypto_reg_if: RTL and testbench

//  Parametrised register front-end for the symmetric-cipher cores (AES-128/192/256 class).

---
 rtl/crypto_reg_if.sv | 218 +++++++++++++++++++++
 tb/tb_crypto_reg_if.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_reg_if.sv
// crypto_reg_if: register front-end for one symmetric-cipher core.
// Holds the key and plaintext words. Launches the core through an IDLE/LOAD/BUSY
// sequence and captures the result. Adds status, sticky error and a level interrupt.
// Optional feature macro: CRYPTO_REG_TIMEOUT_EN adds a BUSY watchdog and STATUS[3].
// Ports:
//   mclk, rst        clock, synchronous active-high reset
//   reg_*            word-addressed register bus; rdata/ack are registered
//   cfg_ld           one-cycle load/start pulse to the core
//   cfg_key_len      0=128 1=192 2=256 (3 treated as 256 by the core)
//   cfg_key          key words, word0 = LSW
//   cfg_text_in      input block, word0 = LSW
//   core_done        completion pulse; core_text_out is valid with it
//   irq              level interrupt = done & irq_en
module crypto_reg_if #(
  parameter int unsigned KEY_W  = 256,
  parameter int unsigned BLK_W  = 128,
  parameter int unsigned TO_CYC = 1024
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             reg_cs,
  input  logic [4:0]       reg_addr,
  input  logic             reg_wr,
  input  logic [31:0]      reg_wdata,
  input  logic [3:0]       reg_be,
  output logic [31:0]      reg_rdata,
  output logic             reg_ack,
  output logic             cfg_ld,
  output logic [1:0]       cfg_key_len,
  output logic [KEY_W-1:0] cfg_key,
  output logic [BLK_W-1:0] cfg_text_in,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_text_out,
  output logic             irq
);

  localparam int unsigned KEY_WORDS = KEY_W / 32;
  localparam int unsigned TXT_WORDS = BLK_W / 32;

  // Reject parameter sets the register map cannot represent.
  if (KEY_W % 32 != 0 || KEY_WORDS > 8 || BLK_W != 128 || TO_CYC < 2) begin : g_bad_param
    $error("crypto_reg_if: unsupported KEY_W/BLK_W/TO_CYC");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_BUSY} state_t;

  state_t      state_q, state_d;
  logic        start_q;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        to_hit;
  logic        to_flag;
  logic        hw_done;
  logic [31:0] key_q [KEY_WORDS];
  logic [31:0] txt_in_q [TXT_WORDS];
  logic [31:0] txt_out_q [TXT_WORDS];
  logic [31:0] rd_mux;

  // Bus decode; an access is taken only in the cycle before its ack.
  logic       acc, wr_acc, ctrl_wr, status_wr;
  logic       key_hit, key_valid, text_hit, tout_hit;
  logic [2:0] key_off;
  logic       busy, start_ok, drop_err;

  assign acc       = reg_cs && !reg_ack;
  assign wr_acc    = acc && reg_wr;
  assign ctrl_wr   = wr_acc && (reg_addr == 5'h00);
  assign status_wr = wr_acc && (reg_addr == 5'h01);
  assign key_hit   = (reg_addr >= 5'h04) && (reg_addr <= 5'h0B);
  assign key_off   = 3'(reg_addr - 5'h04);
  assign key_valid = key_hit && (32'(key_off) < KEY_WORDS);
  assign text_hit  = (reg_addr[4:2] == 3'b011);
  assign tout_hit  = (reg_addr[4:2] == 3'b100);

  // A start accepted but not yet in LOAD already counts as busy.
  assign busy      = (state_q != ST_IDLE) || start_q;
  assign start_ok  = ctrl_wr && reg_be[0] && reg_wdata[0] && !busy;
  assign drop_err  = busy && ((ctrl_wr && reg_be[0]) ||
                              (wr_acc && (key_valid || text_hit)));

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

`ifdef CRYPTO_REG_TIMEOUT_EN
  localparam int unsigned TO_CW = $clog2(TO_CYC) + 1;
  logic [TO_CW-1:0] to_cnt_q;
  logic             to_flag_q;

  assign to_hit  = (state_q == ST_BUSY) && !core_done &&
                   (to_cnt_q == TO_CW'(TO_CYC - 1));
  assign to_flag = to_flag_q;

  // Watchdog: cleared on LOAD entry, counts BUSY cycles; flag is W1C, set wins.
  always_ff @(posedge mclk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      if (state_d == ST_LOAD)       to_cnt_q <= '0;
      else if (state_q == ST_BUSY)  to_cnt_q <= to_cnt_q + TO_CW'(1);
      if (to_hit)                                         to_flag_q <= 1'b1;
      else if (status_wr && reg_be[0] && reg_wdata[3])    to_flag_q <= 1'b0;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign to_flag = 1'b0;
`endif

  // FSM next state; completion is only honoured in BUSY.
  always_comb begin
    state_d = state_q;
    hw_done = 1'b0;
    case (state_q)
      ST_IDLE: if (start_q) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_BUSY;
      ST_BUSY: begin
        if (core_done) begin
          hw_done = 1'b1;
          state_d = ST_IDLE;
        end else if (to_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status next values: W1C clears first so a same-cycle hardware set wins.
  always_comb begin
    done_d   = done_q;
    err_d    = err_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr && reg_be[0]) irq_en_d = reg_wdata[1];
    if (status_wr && reg_be[0]) begin
      if (reg_wdata[1]) done_d = 1'b0;
      if (reg_wdata[2]) err_d  = 1'b0;
    end
    if (hw_done)            done_d = 1'b1;
    if (drop_err || to_hit) err_d  = 1'b1;
  end

  // Read data mux.
  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      5'h00:   rd_mux = {28'd0, cfg_key_len, irq_en_q, 1'b0};
      5'h01:   rd_mux = {28'd0, to_flag, err_q, done_q, busy};
      default: begin
        for (int unsigned i = 0; i < KEY_WORDS; i++) begin
          if (key_hit && key_off == 3'(i)) rd_mux = key_q[i];
        end
        for (int unsigned i = 0; i < TXT_WORDS; i++) begin
          if (text_hit && reg_addr[1:0] == 2'(i)) rd_mux = txt_in_q[i];
          if (tout_hit && reg_addr[1:0] == 2'(i)) rd_mux = txt_out_q[i];
        end
      end
    endcase
  end

  // Register file, bus handshake and FSM state.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      cfg_ld      <= 1'b0;
      reg_ack     <= 1'b0;
      reg_rdata   <= '0;
      irq_en_q    <= 1'b0;
      cfg_key_len <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq         <= 1'b0;
      for (int unsigned i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
      for (int unsigned i = 0; i < TXT_WORDS; i++) begin
        txt_in_q[i]  <= '0;
        txt_out_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      start_q   <= start_ok;
      cfg_ld    <= (state_d == ST_LOAD);
      reg_ack   <= acc;
      reg_rdata <= (acc && !reg_wr) ? rd_mux : 32'd0;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      irq       <= done_d && irq_en_d;
      if (ctrl_wr && reg_be[0] && !busy) cfg_key_len <= reg_wdata[3:2];
      for (int unsigned i = 0; i < KEY_WORDS; i++) begin
        if (wr_acc && !busy && key_hit && key_off == 3'(i))
          key_q[i] <= be_merge(key_q[i], reg_wdata, reg_be);
      end
      for (int unsigned i = 0; i < TXT_WORDS; i++) begin
        if (wr_acc && !busy && text_hit && reg_addr[1:0] == 2'(i))
          txt_in_q[i] <= be_merge(txt_in_q[i], reg_wdata, reg_be);
        if (hw_done) txt_out_q[i] <= core_text_out[32*i +: 32];
      end
    end
  end

  for (genvar i = 0; i < KEY_WORDS; i++) begin : g_key
    assign cfg_key[32*i +: 32] = key_q[i];
  end
  for (genvar i = 0; i < TXT_WORDS; i++) begin : g_txt
    assign cfg_text_in[32*i +: 32] = txt_in_q[i];
  end

endmodule

// File: tb/tb_crypto_reg_if.sv
// Bench for crypto_reg_if: a 256-bit-key instance and a 128-bit-key instance
// share one bus. Reads push expected data into a scoreboard queue; a monitor
// pops and compares on every reg_ack.
module tb_crypto_reg_if;
  logic         mclk = 1'b0;
  logic         rst  = 1'b1;
  logic         reg_cs = 1'b0;
  logic [4:0]   reg_addr = '0;
  logic         reg_wr = 1'b0;
  logic [31:0]  reg_wdata = '0;
  logic [3:0]   reg_be = '0;
  logic         core_done = 1'b0;
  logic [127:0] core_text_out = '0;

  logic [31:0]  rdata_a, rdata_b;
  logic         ack_a, ack_b, ld_a, ld_b, irq_a, irq_b;
  logic [1:0]   kl_a, kl_b;
  logic [255:0] key_a;
  logic [127:0] key_b, txt_a, txt_b;

  always #5 mclk = ~mclk;

  crypto_reg_if #(.KEY_W(256), .BLK_W(128), .TO_CYC(16)) u_dut (
    .mclk(mclk), .rst(rst), .reg_cs(reg_cs), .reg_addr(reg_addr), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(rdata_a), .reg_ack(ack_a),
    .cfg_ld(ld_a), .cfg_key_len(kl_a), .cfg_key(key_a), .cfg_text_in(txt_a),
    .core_done(core_done), .core_text_out(core_text_out), .irq(irq_a));

  crypto_reg_if #(.KEY_W(128), .BLK_W(128), .TO_CYC(16)) u_dut128 (
    .mclk(mclk), .rst(rst), .reg_cs(reg_cs), .reg_addr(reg_addr), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(rdata_b), .reg_ack(ack_b),
    .cfg_ld(ld_b), .cfg_key_len(kl_b), .cfg_key(key_b), .cfg_text_in(txt_b),
    .core_done(core_done), .core_text_out(core_text_out), .irq(irq_b));

  int n_vec = 0;
  int n_bad = 0;
  int ld_cnt = 0;

  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  bit          chk_q[$];
  string       name_q[$];

  always @(negedge mclk) if (ld_a) ld_cnt++;

  // Scoreboard monitor.
  always @(negedge mclk) begin
    if (ack_a) begin
      if (name_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL spurious_ack: ack with no access outstanding");
      end else begin
        logic [31:0] ea, eb;
        bit          c;
        string       nm;
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        c  = chk_q.pop_front();
        nm = name_q.pop_front();
        n_vec++;
        if (ack_b !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_ack128: got %b exp 1", nm, ack_b);
        end
        if (c) begin
          n_vec++;
          if (rdata_a !== ea) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", nm, rdata_a, ea);
          end
          n_vec++;
          if (rdata_b !== eb) begin
            n_bad++;
            $display("FAIL %s_k128: got %h exp %h", nm, rdata_b, eb);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge mclk);
    reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d; reg_be = be;
    exp_a_q.push_back('0); exp_b_q.push_back('0); chk_q.push_back(1'b0); name_q.push_back("wr");
    @(posedge mclk);
    @(negedge mclk);
    reg_cs = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] ea, input logic [31:0] eb,
                    input string nm);
    @(negedge mclk);
    reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = a; reg_be = 4'hF;
    exp_a_q.push_back(ea); exp_b_q.push_back(eb); chk_q.push_back(1'b1); name_q.push_back(nm);
    @(posedge mclk);
    @(negedge mclk);
    reg_cs = 1'b0;
  endtask

  task automatic core_pulse(input logic [127:0] d);
    @(negedge mclk);
    core_done = 1'b1; core_text_out = d;
    @(negedge mclk);
    core_done = 1'b0; core_text_out = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res;
    res = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

    repeat (3) @(negedge mclk);
    rst = 1'b0;
    chk("rst_ack", 256'(ack_a), 256'd0);
    chk("rst_rdata", 256'(rdata_a), 256'd0);
    chk("rst_irq", 256'(irq_a), 256'd0);
    chk("rst_cfg_key", key_a, 256'd0);
    chk("rst_cfg_text", 256'(txt_a), 256'd0);
    chk("rst_key_len", 256'(kl_a), 256'd0);
    for (int i = 0; i < 20; i++) rd(5'(i), 32'd0, 32'd0, "rst_read");
    rd(5'h1F, 32'd0, 32'd0, "rst_read_1f");

    // CTRL read-back, irq stays low with done=0.
    wr(5'h00, 32'h2, 4'hF);
    rd(5'h00, 32'h2, 32'h2, "ctrl_irq_en");
    chk("irq_no_done", 256'(irq_a), 256'd0);

    // Byte enables on KEY0.
    wr(5'h04, 32'h03020100, 4'h3);
    wr(5'h04, 32'hAABBCCDD, 4'hC);
    rd(5'h04, 32'hAABB0100, 32'hAABB0100, "key0_be");

    // Upper key words exist only in the 256-bit instance.
    wr(5'h08, 32'h12345678, 4'hF);
    wr(5'h0B, 32'h77777777, 4'hF);
    rd(5'h08, 32'h12345678, 32'd0, "key4");
    rd(5'h0B, 32'h77777777, 32'd0, "key7");
    chk("cfg_key_256", key_a, {32'h77777777, 64'd0, 32'h12345678, 96'd0, 32'hAABB0100});
    chk("cfg_key_128", 256'(key_b), 256'h0_AABB0100);

    // Unmapped address: write ignored.
    wr(5'h14, 32'hDEADBEEF, 4'hF);
    rd(5'h14, 32'd0, 32'd0, "unmapped");

    wr(5'h0C, 32'h00112233, 4'hF);
    wr(5'h0D, 32'h44556677, 4'hF);
    wr(5'h0E, 32'h8899AABB, 4'hF);
    wr(5'h0F, 32'hCCDDEEFF, 4'hF);
    rd(5'h0E, 32'h8899AABB, 32'h8899AABB, "text_in2");
    chk("cfg_text_in", 256'(txt_a), 256'(128'hCCDDEEFF_8899AABB_44556677_00112233));
    wr(5'h00, 32'hA, 4'hF);
    chk("key_len", 256'(kl_a), 256'd2);

    // Start: cfg_ld exactly one cycle, one cycle after the write ack.
    wr(5'h00, 32'hB, 4'hF);
    chk("ld_not_yet_before", 256'(ld_cnt), 256'd0);
    @(negedge mclk);
    chk("ld_high", 256'(ld_a), 256'd1);
    @(negedge mclk);
    chk("ld_low", 256'(ld_a), 256'd0);
    rd(5'h01, 32'h1, 32'h1, "status_busy");
    rd(5'h00, 32'hA, 32'hA, "ctrl_start_reads0");

    // Writes and restart while busy are dropped and flag err.
    wr(5'h0C, 32'hFFFFFFFF, 4'hF);
    wr(5'h00, 32'h3, 4'hF);
    rd(5'h0C, 32'h00112233, 32'h00112233, "text_in_locked");
    rd(5'h01, 32'h5, 32'h5, "status_busy_err");
    rd(5'h00, 32'hA, 32'hA, "ctrl_key_len_locked");
    chk("ld_single", 256'(ld_cnt), 256'd1);

    // Completion.
    core_pulse(res);
    chk("irq_done", 256'(irq_a), 256'd1);
    rd(5'h01, 32'h6, 32'h6, "status_done_err");
    rd(5'h10, 32'h70B4C55A, 32'h70B4C55A, "text_out0");
    rd(5'h11, 32'hD8CDB780, 32'hD8CDB780, "text_out1");
    rd(5'h12, 32'h6A7B0430, 32'h6A7B0430, "text_out2");
    rd(5'h13, 32'h69C4E0D8, 32'h69C4E0D8, "text_out3");
    wr(5'h01, 32'h2, 4'hF);
    chk("irq_cleared", 256'(irq_a), 256'd0);
    rd(5'h01, 32'h4, 32'h4, "status_err_only");
    wr(5'h01, 32'h4, 4'hF);
    rd(5'h01, 32'h0, 32'h0, "status_clear");

    // Stray completion while idle is ignored.
    core_pulse({4{32'h11111111}});
    rd(5'h10, 32'h70B4C55A, 32'h70B4C55A, "text_out_hold");
    rd(5'h01, 32'h0, 32'h0, "status_idle_done");

    // Reset in BUSY aborts; a later completion is ignored.
    wr(5'h00, 32'hB, 4'hF);
    repeat (4) @(negedge mclk);
    rst = 1'b1;
    repeat (2) @(negedge mclk);
    rst = 1'b0;
    core_pulse(res);
    chk("irq_after_abort", 256'(irq_a), 256'd0);
    chk("cfg_key_after_rst", key_a, 256'd0);
    rd(5'h01, 32'h0, 32'h0, "status_after_abort");
    rd(5'h10, 32'h0, 32'h0, "text_out_after_abort");
    rd(5'h00, 32'h0, 32'h0, "ctrl_after_rst");
    wr(5'h10, 32'h55555555, 4'hF);
    rd(5'h10, 32'h0, 32'h0, "text_out_ro");

    // No completion: with the watchdog the op ends with err+timeout, else it stays busy.
    wr(5'h00, 32'h1, 4'hF);
    repeat (24) @(negedge mclk);
`ifdef CRYPTO_REG_TIMEOUT_EN
    rd(5'h01, 32'hC, 32'hC, "status_timeout");
    rd(5'h10, 32'h0, 32'h0, "text_out_timeout");
    wr(5'h01, 32'h8, 4'hF);
    rd(5'h01, 32'h4, 32'h4, "status_to_w1c");
`else
    rd(5'h01, 32'h1, 32'h1, "status_still_busy");
`endif

    repeat (4) @(negedge mclk);
    n_vec++;
    if (name_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d outstanding acks exp 0", name_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
